// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-port, fixed-latency RAM between the instruction-fetch
// requester (if*) and the memory-access requester (mem*). A request seen in
// IDLE is latched, issued to the RAM as a one-cycle command, the RAM latency
// is waited out, and the owner receives a one-cycle valid pulse together with
// its read data. MEM has priority; fetch is forced through after it has lost
// STARVE_LIMIT consecutive contested arbitrations.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   ifReq/ifAddr                fetch read request, held until ifValid
//   ifValid/ifReadData          fetch completion pulse and fetched word
//   ifStall                     ifReq & ~ifValid (combinational)
//   memReq/memWrite/memAddr/
//   memWriteData                data request, held until memValid
//   memValid/memReadData        data completion pulse and load data
//   memStall                    memReq & ~memValid (combinational)
//   ramEnable/ramWrite/ramAddr/
//   ramWriteData                registered one-cycle RAM command
//   ramReadData                 RAM read data, valid MEM_LATENCY cycles after ramEnable
//   busy                        arbiter is not in IDLE
module memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifReq,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  output logic                  ifValid,
  output logic [DATA_WIDTH-1:0] ifReadData,
  output logic                  ifStall,
  input  logic                  memReq,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memValid,
  output logic [DATA_WIDTH-1:0] memReadData,
  output logic                  memStall,
  output logic                  ramEnable,
  output logic                  ramWrite,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0] ramWriteData,
  input  logic [DATA_WIDTH-1:0] ramReadData,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  localparam logic [3:0] LATENCY_LOAD = 4'(MEM_LATENCY);
  localparam logic [2:0] STARVE_MAX   = 3'(STARVE_LIMIT);

  state_t                  state_r;
  state_t                  stateNext_s;
  logic                    grantIf_s;
  logic                    grantMem_s;
  logic                    finish_s;
  logic                    ownerMem_r;
  logic                    reqWrite_r;
  logic [2:0]              starveCount_r;
  logic [3:0]              latCount_r;
  logic                    ifValid_r;
  logic                    memValid_r;
  logic [DATA_WIDTH-1:0]   ifReadData_r;
  logic [DATA_WIDTH-1:0]   memReadData_r;
  logic                    ramEnable_r;
  logic                    ramWrite_r;
  logic [ADDR_WIDTH-1:0]   ramAddr_r;
  logic [DATA_WIDTH-1:0]   ramWriteData_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic, arbitration decision and completion strobe.
  always_comb begin
    stateNext_s = state_r;
    grantIf_s   = 1'b0;
    grantMem_s  = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (ifReq && memReq) begin
          // Contested: MEM wins unless fetch has been starved long enough.
          if (starveCount_r == STARVE_MAX) begin
            grantIf_s = 1'b1;
          end else begin
            grantMem_s = 1'b1;
          end
          stateNext_s = ISSUE;
        end else if (ifReq) begin
          grantIf_s   = 1'b1;
          stateNext_s = ISSUE;
        end else if (memReq) begin
          grantMem_s  = 1'b1;
          stateNext_s = ISSUE;
        end else begin
          stateNext_s = IDLE;
        end
      end
      ISSUE: begin
        stateNext_s = WAIT;
      end
      WAIT: begin
        // Counter reads 1 in the cycle the RAM presents read data.
        if (latCount_r == 4'd1) begin
          finish_s    = 1'b1;
          stateNext_s = RESPOND;
        end else begin
          stateNext_s = WAIT;
        end
      end
      RESPOND: begin
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Datapath: RAM command, latency counter, starvation counter, responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      ownerMem_r     <= 1'b0;
      reqWrite_r     <= 1'b0;
      starveCount_r  <= 3'd0;
      latCount_r     <= 4'd0;
      ifValid_r      <= 1'b0;
      memValid_r     <= 1'b0;
      ifReadData_r   <= '0;
      memReadData_r  <= '0;
      ramEnable_r    <= 1'b0;
      ramWrite_r     <= 1'b0;
      ramAddr_r      <= '0;
      ramWriteData_r <= '0;
    end else begin
      // The command registers are loaded on the grant edge so that they are
      // visible exactly during the ISSUE cycle.
      ramEnable_r <= grantIf_s | grantMem_s;
      ramWrite_r  <= grantMem_s & memWrite;
      if (grantIf_s) begin
        ramAddr_r  <= ifAddr;
        ownerMem_r <= 1'b0;
        reqWrite_r <= 1'b0;
      end else if (grantMem_s) begin
        ramAddr_r      <= memAddr;
        ramWriteData_r <= memWriteData;
        ownerMem_r     <= 1'b1;
        reqWrite_r     <= memWrite;
      end

      if (grantIf_s) begin
        starveCount_r <= 3'd0;
      end else if (grantMem_s && ifReq && (starveCount_r != STARVE_MAX)) begin
        starveCount_r <= starveCount_r + 3'd1;
      end

      if (state_r == ISSUE) begin
        latCount_r <= LATENCY_LOAD;
      end else if ((state_r == WAIT) && (latCount_r != 4'd0)) begin
        latCount_r <= latCount_r - 4'd1;
      end

      ifValid_r  <= finish_s & ~ownerMem_r;
      memValid_r <= finish_s & ownerMem_r;

      // Read data registers only change when their owner completes a read.
      if (finish_s && !reqWrite_r) begin
        if (ownerMem_r) begin
          memReadData_r <= ramReadData;
        end else begin
          ifReadData_r <= ramReadData;
        end
      end
    end
  end

  assign ifValid      = ifValid_r;
  assign memValid     = memValid_r;
  assign ifReadData   = ifReadData_r;
  assign memReadData  = memReadData_r;
  assign ramEnable    = ramEnable_r;
  assign ramWrite     = ramWrite_r;
  assign ramAddr      = ramAddr_r;
  assign ramWriteData = ramWriteData_r;
  assign busy         = (state_r != IDLE);
  assign ifStall      = ifReq & ~ifValid_r;
  assign memStall     = memReq & ~memValid_r;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        ifReq, memReq, memWrite;
  logic [31:0] ifAddr, memAddr, memWriteData, ramReadData;
  logic        ifValid, ifStall, memValid, memStall, ramEnable, ramWrite, busy;
  logic [31:0] ifReadData, memReadData, ramAddr, ramWriteData;

  logic        l1IfReq, l1MemReq, l1MemWrite;
  logic [31:0] l1IfAddr, l1MemAddr, l1MemWriteData, l1RamReadData;
  logic        l1IfValid, l1IfStall, l1MemValid, l1MemStall, l1RamEnable, l1RamWrite, l1Busy;
  logic [31:0] l1IfReadData, l1MemReadData, l1RamAddr, l1RamWriteData;

  int nTests = 0;
  int nFail  = 0;

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifValid(ifValid), .ifReadData(ifReadData), .ifStall(ifStall),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWriteData(memWriteData),
    .memValid(memValid), .memReadData(memReadData), .memStall(memStall),
    .ramEnable(ramEnable), .ramWrite(ramWrite), .ramAddr(ramAddr), .ramWriteData(ramWriteData),
    .ramReadData(ramReadData), .busy(busy)
  );

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) dutL1 (
    .clk(clk), .reset(reset),
    .ifReq(l1IfReq), .ifAddr(l1IfAddr), .ifValid(l1IfValid), .ifReadData(l1IfReadData), .ifStall(l1IfStall),
    .memReq(l1MemReq), .memWrite(l1MemWrite), .memAddr(l1MemAddr), .memWriteData(l1MemWriteData),
    .memValid(l1MemValid), .memReadData(l1MemReadData), .memStall(l1MemStall),
    .ramEnable(l1RamEnable), .ramWrite(l1RamWrite), .ramAddr(l1RamAddr), .ramWriteData(l1RamWriteData),
    .ramReadData(l1RamReadData), .busy(l1Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ifReq = 1'b0; ifAddr = 32'd0; memReq = 1'b0; memWrite = 1'b0; memAddr = 32'd0;
    memWriteData = 32'd0; ramReadData = 32'd0;
    l1IfReq = 1'b0; l1IfAddr = 32'd0; l1MemReq = 1'b0; l1MemWrite = 1'b0; l1MemAddr = 32'd0;
    l1MemWriteData = 32'd0; l1RamReadData = 32'd0;
    tick(); tick(); #1;
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL rst_busy got %0b exp 0", busy); end
    nTests++; if ({ifValid, memValid, ramEnable, ramWrite} !== 4'b0000) begin nFail++; $display("FAIL rst_strobes got %b exp 0000", {ifValid, memValid, ramEnable, ramWrite}); end
    nTests++; if ({ramAddr, ramWriteData} !== 64'd0) begin nFail++; $display("FAIL rst_ram got %h/%h exp 0", ramAddr, ramWriteData); end
    nTests++; if ({ifReadData, memReadData} !== 64'd0) begin nFail++; $display("FAIL rst_rdata got %h/%h exp 0", ifReadData, memReadData); end
    nTests++; if ({ifStall, memStall} !== 2'b00) begin nFail++; $display("FAIL rst_stall got %b exp 00", {ifStall, memStall}); end
    nTests++; if (l1Busy !== 1'b0) begin nFail++; $display("FAIL rst_l1_busy got %0b exp 0", l1Busy); end
    reset = 1'b0;
  endtask

  task automatic test_if_read;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) begin ifReq = 1'b1; ifAddr = 32'h10; end
      if (c == 5) ifReq = 1'b0;
      ramReadData = (c == 3) ? 32'hDEADBEEF : (32'h0BAD0000 + 32'(c));
      #1;
      nTests++; if (ramEnable !== (c == 1)) begin nFail++; $display("FAIL ifrd_en c=%0d got %0b exp %0b", c, ramEnable, (c == 1)); end
      if (c == 1) begin
        nTests++; if (ramAddr !== 32'h10 || ramWrite !== 1'b0) begin nFail++; $display("FAIL ifrd_cmd got addr %h wr %0b exp 10/0", ramAddr, ramWrite); end
      end
      nTests++; if (ifValid !== (c == 4) || memValid !== 1'b0) begin nFail++; $display("FAIL ifrd_valid c=%0d got %0b%0b exp %0b0", c, ifValid, memValid, (c == 4)); end
      if (c == 4) begin
        nTests++; if (ifReadData !== 32'hDEADBEEF) begin nFail++; $display("FAIL ifrd_data got %h exp deadbeef", ifReadData); end
      end
      nTests++; if (ifStall !== (c <= 3)) begin nFail++; $display("FAIL ifrd_stall c=%0d got %0b exp %0b", c, ifStall, (c <= 3)); end
    end
  endtask

  task automatic test_mem_write;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) begin memReq = 1'b1; memWrite = 1'b1; memAddr = 32'h40; memWriteData = 32'h12345678; end
      if (c == 5) begin memReq = 1'b0; memWrite = 1'b0; end
      ramReadData = 32'hA5A50000 + 32'(c);
      #1;
      nTests++; if (ramEnable !== (c == 1) || ramWrite !== (c == 1)) begin nFail++; $display("FAIL mwr_en c=%0d got %0b%0b exp %0b", c, ramEnable, ramWrite, (c == 1)); end
      if (c == 1) begin
        nTests++; if (ramAddr !== 32'h40 || ramWriteData !== 32'h12345678) begin nFail++; $display("FAIL mwr_cmd got %h/%h exp 40/12345678", ramAddr, ramWriteData); end
      end
      nTests++; if (memValid !== (c == 4) || ifValid !== 1'b0) begin nFail++; $display("FAIL mwr_valid c=%0d got %0b%0b exp %0b0", c, memValid, ifValid, (c == 4)); end
      nTests++; if (memReadData !== 32'd0 || ifReadData !== 32'hDEADBEEF) begin nFail++; $display("FAIL mwr_hold got %h/%h exp 0/deadbeef", memReadData, ifReadData); end
    end
  endtask

  task automatic test_simultaneous;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (c == 0) begin memReq = 1'b1; memWrite = 1'b0; memAddr = 32'h80; ifReq = 1'b1; ifAddr = 32'h90; end
      if (c == 5) memReq = 1'b0;
      if (c == 10) ifReq = 1'b0;
      ramReadData = (c == 3) ? 32'hAAAA0001 : ((c == 8) ? 32'hBBBB0002 : 32'h77770000 + 32'(c));
      #1;
      nTests++; if (ramEnable !== (c == 1 || c == 6)) begin nFail++; $display("FAIL sim_en c=%0d got %0b", c, ramEnable); end
      if (c == 1 || c == 6) begin
        nTests++; if (ramAddr !== ((c == 1) ? 32'h80 : 32'h90)) begin nFail++; $display("FAIL sim_addr c=%0d got %h exp %h", c, ramAddr, (c == 1) ? 32'h80 : 32'h90); end
      end
      nTests++; if (memValid !== (c == 4) || ifValid !== (c == 9)) begin nFail++; $display("FAIL sim_valid c=%0d got m%0b i%0b", c, memValid, ifValid); end
      if (c == 4) begin
        nTests++; if (memReadData !== 32'hAAAA0001) begin nFail++; $display("FAIL sim_mdata got %h exp aaaa0001", memReadData); end
      end
      if (c == 9) begin
        nTests++; if (ifReadData !== 32'hBBBB0002) begin nFail++; $display("FAIL sim_idata got %h exp bbbb0002", ifReadData); end
      end
    end
  endtask

  task automatic test_starvation;
    logic [31:0] expA;
    for (int c = 0; c < 31; c++) begin
      tick();
      if (c == 0) begin ifReq = 1'b1; ifAddr = 32'h100; memReq = 1'b1; memWrite = 1'b0; memAddr = 32'h200; end
      if (c == 5 || c == 10 || c == 15 || c == 20) memAddr = memAddr + 32'd4;
      if (c == 25) ifReq = 1'b0;
      if (c == 30) memReq = 1'b0;
      ramReadData = 32'h50000000 + 32'(c);
      #1;
      nTests++; if (ramEnable !== (c % 5 == 1)) begin nFail++; $display("FAIL stv_en c=%0d got %0b exp %0b", c, ramEnable, (c % 5 == 1)); end
      if (c % 5 == 1) begin
        if (c / 5 < 4) expA = 32'h200 + 32'(4 * (c / 5));
        else if (c / 5 == 4) expA = 32'h100;
        else expA = 32'h210;
        nTests++; if (ramAddr !== expA) begin nFail++; $display("FAIL stv_addr c=%0d got %h exp %h", c, ramAddr, expA); end
      end
      nTests++; if (ifValid !== (c == 24)) begin nFail++; $display("FAIL stv_ivalid c=%0d got %0b exp %0b", c, ifValid, (c == 24)); end
      nTests++; if (memValid !== (c % 5 == 4 && c != 24)) begin nFail++; $display("FAIL stv_mvalid c=%0d got %0b", c, memValid); end
    end
  endtask

  task automatic test_reset_mid_wait;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c == 0) begin ifReq = 1'b1; ifAddr = 32'h300; end
      reset = (c == 2);
      if (c == 8) ifReq = 1'b0;
      ramReadData = (c == 6) ? 32'hCAFEF00D : 32'h33330000 + 32'(c);
      #1;
      if (c == 3) begin
        nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL rmw_busy got %0b exp 0", busy); end
        nTests++; if ({ramAddr, ifReadData, memReadData} !== 96'd0) begin nFail++; $display("FAIL rmw_clear got %h %h %h exp 0", ramAddr, ifReadData, memReadData); end
      end
      nTests++; if (ifValid !== (c == 7) || memValid !== 1'b0) begin nFail++; $display("FAIL rmw_valid c=%0d got i%0b m%0b", c, ifValid, memValid); end
      nTests++; if (ramEnable !== (c == 1 || c == 4)) begin nFail++; $display("FAIL rmw_en c=%0d got %0b", c, ramEnable); end
      nTests++; if (busy !== ((c >= 1 && c <= 2) || (c >= 4 && c <= 7))) begin nFail++; $display("FAIL rmw_busyseq c=%0d got %0b", c, busy); end
      if (c == 4) begin
        nTests++; if (ramAddr !== 32'h300) begin nFail++; $display("FAIL rmw_addr got %h exp 300", ramAddr); end
      end
      if (c == 7) begin
        nTests++; if (ifReadData !== 32'hCAFEF00D) begin nFail++; $display("FAIL rmw_data got %h exp cafef00d", ifReadData); end
      end
    end
  endtask

  task automatic test_latency1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) begin l1MemReq = 1'b1; l1MemWrite = 1'b0; l1MemAddr = 32'h20; end
      if (c == 4) l1MemReq = 1'b0;
      l1RamReadData = (c == 2) ? 32'h1234ABCD : 32'hFFFF0000 + 32'(c);
      #1;
      nTests++; if (l1RamEnable !== (c == 1)) begin nFail++; $display("FAIL l1_en c=%0d got %0b", c, l1RamEnable); end
      if (c == 1) begin
        nTests++; if (l1RamAddr !== 32'h20) begin nFail++; $display("FAIL l1_addr got %h exp 20", l1RamAddr); end
      end
      nTests++; if (l1MemValid !== (c == 3)) begin nFail++; $display("FAIL l1_valid c=%0d got %0b", c, l1MemValid); end
      if (c == 3) begin
        nTests++; if (l1MemReadData !== 32'h1234ABCD) begin nFail++; $display("FAIL l1_data got %h exp 1234abcd", l1MemReadData); end
      end
      nTests++; if (l1Busy !== (c >= 1 && c <= 3)) begin nFail++; $display("FAIL l1_busy c=%0d got %0b", c, l1Busy); end
    end
  endtask

  // Transaction-level model: each accepted request occupies the RAM for
  // LAT+3 cycles starting at its sampling cycle; the RAM itself is a small array.
  task automatic test_random;
    logic [31:0] ramMem [16];
    logic [31:0] refMem [16];
    logic [31:0] expIfData, expMemData, expAddr, expWdata;
    logic        ownMem, expWrite, expEn, expIfV, expMemV, winMem;
    logic        ifPending, memPending, draining, drained;
    int          freeAt, issueCyc, doneCyc, ramDue, starve;
    logic [3:0]  ramDueAddr;
    for (int i = 0; i < 16; i++) begin ramMem[i] = $urandom(); refMem[i] = ramMem[i]; end
    reset = 1'b1; ifReq = 1'b0; memReq = 1'b0; memWrite = 1'b0;
    tick(); tick();
    reset = 1'b0;
    expIfData = 32'd0; expMemData = 32'd0; expAddr = 32'd0; expWdata = 32'd0;
    ownMem = 1'b0; expWrite = 1'b0; ifPending = 1'b0; memPending = 1'b0;
    draining = 1'b0; drained = 1'b0;
    freeAt = 0; issueCyc = -1; doneCyc = -1; ramDue = -1; starve = 0; ramDueAddr = 4'd0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      // RAM environment
      if (ramEnable) begin
        if (ramWrite) ramMem[ramAddr[3:0]] = ramWriteData;
        else begin ramDue = k + LAT; ramDueAddr = ramAddr[3:0]; end
      end
      ramReadData = (k == ramDue) ? ramMem[ramDueAddr] : $urandom();
      expEn   = (k == issueCyc);
      expIfV  = (k == doneCyc) && !ownMem;
      expMemV = (k == doneCyc) && ownMem;
      if (k >= 700) draining = 1'b1;
      // requesters
      if (expIfV) ifPending = 1'b0;
      else if (!ifPending && !draining && $urandom_range(0, 99) < 60) begin
        ifReq = 1'b1; ifAddr = 32'($urandom_range(0, 15)); ifPending = 1'b1;
      end else if (!ifPending) ifReq = 1'b0;
      if (expMemV) memPending = 1'b0;
      else if (!memPending && !draining && $urandom_range(0, 99) < 60) begin
        memReq = 1'b1; memAddr = 32'($urandom_range(0, 15)); memWrite = ($urandom_range(0, 99) < 40);
        memWriteData = $urandom(); memPending = 1'b1;
      end else if (!memPending) memReq = 1'b0;
      #1;
      if (expEn && expWrite) refMem[expAddr[3:0]] = expWdata;
      if (k == doneCyc && !expWrite) begin
        if (ownMem) expMemData = refMem[expAddr[3:0]];
        else expIfData = refMem[expAddr[3:0]];
      end
      nTests++; if (ramEnable !== expEn || ramWrite !== (expEn & expWrite)) begin nFail++; $display("FAIL rnd_cmd k=%0d got en%0b wr%0b exp en%0b wr%0b", k, ramEnable, ramWrite, expEn, expEn & expWrite); end
      if (expEn) begin
        nTests++; if (ramAddr !== expAddr) begin nFail++; $display("FAIL rnd_addr k=%0d got %h exp %h", k, ramAddr, expAddr); end
        if (expWrite) begin
          nTests++; if (ramWriteData !== expWdata) begin nFail++; $display("FAIL rnd_wdata k=%0d got %h exp %h", k, ramWriteData, expWdata); end
        end
      end
      nTests++; if (ifValid !== expIfV || memValid !== expMemV) begin nFail++; $display("FAIL rnd_valid k=%0d got i%0b m%0b exp i%0b m%0b", k, ifValid, memValid, expIfV, expMemV); end
      nTests++; if (ifReadData !== expIfData || memReadData !== expMemData) begin nFail++; $display("FAIL rnd_rdata k=%0d got %h/%h exp %h/%h", k, ifReadData, memReadData, expIfData, expMemData); end
      nTests++; if (busy !== (k < freeAt)) begin nFail++; $display("FAIL rnd_busy k=%0d got %0b exp %0b", k, busy, (k < freeAt)); end
      nTests++; if (ifStall !== (ifReq & ~expIfV) || memStall !== (memReq & ~expMemV)) begin nFail++; $display("FAIL rnd_stall k=%0d got %0b%0b", k, ifStall, memStall); end
      // arbitration in an idle cycle
      if (k >= freeAt && (ifReq || memReq)) begin
        winMem = memReq && !(ifReq && starve == LIMIT);
        if (!winMem) starve = 0;
        else if (ifReq && starve < LIMIT) starve++;
        ownMem = winMem; expAddr = winMem ? memAddr : ifAddr;
        expWrite = winMem & memWrite; expWdata = memWriteData;
        issueCyc = k + 1; doneCyc = k + 2 + LAT; freeAt = k + LAT + 3;
      end
      if (draining && !ifPending && !memPending && k >= freeAt) begin drained = 1'b1; break; end
    end
    nTests++; if (drained !== 1'b1) begin nFail++; $display("FAIL rnd_drain got pending exp drained"); end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_mem_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_wait();
    test_latency1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
